// File: rtl/rate_scaler_pkg.sv
// Shared constants and FSM encoding for the rate-scaler readout arbiter.
package rate_scaler_pkg;
  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int TS_W = 32;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rate_scaler_readout_arb_rr_pick4.sv
// Combinational 4-way round-robin picker: first set pending bit after last_grant.
module rr_pick4
  import rate_scaler_pkg::*;
(
  input  logic [N_CH-1:0] pending,
  input  logic [CH_W-1:0] last_grant,
  output logic            grant_valid,
  output logic [CH_W-1:0] grant_idx
);

  logic [CH_W-1:0] cand;

  // Walk from lowest to highest priority so the highest-priority hit is assigned last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      cand = last_grant + CH_W'(i + 1);
      if (pending[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rate_scaler_readout_arb.sv
// Four-channel scaler readout arbiter with per-channel overflow tracking.
// Optional timestamp path enabled by defining RATE_SCALER_READOUT_TIMESTAMP_EN.
module rate_scaler_readout_arb
  import rate_scaler_pkg::*;
#(
  parameter int P_N_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CH-1:0]      upd,
  input  logic [P_N_WIDTH-1:0] cnt_0,
  input  logic [P_N_WIDTH-1:0] cnt_1,
  input  logic [P_N_WIDTH-1:0] cnt_2,
  input  logic [P_N_WIDTH-1:0] cnt_3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_chan,
  output logic [P_N_WIDTH-1:0] out_cnt,
  output logic                 out_ovf,
  output logic [N_CH-1:0]      ovf_sticky,
  input  logic                 clr_ovf
`ifdef RATE_SCALER_READOUT_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]      out_ts
`endif
);

  logic [P_N_WIDTH-1:0] cnt_in [N_CH];
  logic [P_N_WIDTH-1:0] hold   [N_CH];
  logic [N_CH-1:0]      pending;
  logic [N_CH-1:0]      overflow;
  logic [N_CH-1:0]      grant_oh;
  logic [N_CH-1:0]      ovf_evt;
  logic [CH_W-1:0]      last_grant;
  logic [CH_W-1:0]      grant_idx;
  logic                 grant_valid;
  logic                 take;
  arb_state_t           state;

  assign cnt_in[0] = cnt_0;
  assign cnt_in[1] = cnt_1;
  assign cnt_in[2] = cnt_2;
  assign cnt_in[3] = cnt_3;

  rr_pick4 u_pick (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign take     = (state == S_IDLE) && grant_valid;
  assign grant_oh = take ? (N_CH'(1) << grant_idx) : '0;
  // A capture that lands in the grant cycle re-arms pending instead of counting as overflow.
  assign ovf_evt  = upd & pending & ~grant_oh;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending    <= '0;
      overflow   <= '0;
      ovf_sticky <= '0;
    end else begin
      pending    <= (pending & ~grant_oh) | upd;
      overflow   <= (overflow & ~grant_oh) | ovf_evt;
      ovf_sticky <= (ovf_sticky & ~{N_CH{clr_ovf}}) | ovf_evt;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (upd[k]) hold[k] <= cnt_in[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= CH_W'(N_CH - 1);
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_cnt    <= '0;
      out_ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_valid) begin
            out_chan   <= grant_idx;
            out_cnt    <= hold[grant_idx];
            out_ovf    <= overflow[grant_idx];
            last_grant <= grant_idx;
            out_valid  <= 1'b1;
            state      <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

`ifdef RATE_SCALER_READOUT_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_hold [N_CH];

  always_ff @(posedge clk) begin
    if (rst) ts <= '0;
    else     ts <= ts + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (upd[k]) ts_hold[k] <= ts;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       out_ts <= '0;
    else if (take) out_ts <= ts_hold[grant_idx];
  end
`endif

endmodule

// File: tb/tb_rate_scaler_readout_arb.sv
// Directed bench for rate_scaler_readout_arb; expected values are hand-derived per step.
module tb_rate_scaler_readout_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  upd;
  logic [31:0] cnt_0, cnt_1, cnt_2, cnt_3;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_chan;
  logic [31:0] out_cnt;
  logic        out_ovf;
  logic [3:0]  ovf_sticky;
  logic        clr_ovf;
`ifdef RATE_SCALER_READOUT_TIMESTAMP_EN
  logic [31:0] out_ts;
  logic [31:0] ts_model;
  logic [31:0] ts_at;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rate_scaler_readout_arb #(.P_N_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .upd        (upd),
    .cnt_0      (cnt_0),
    .cnt_1      (cnt_1),
    .cnt_2      (cnt_2),
    .cnt_3      (cnt_3),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .out_cnt    (out_cnt),
    .out_ovf    (out_ovf),
    .ovf_sticky (ovf_sticky),
    .clr_ovf    (clr_ovf)
`ifdef RATE_SCALER_READOUT_TIMESTAMP_EN
    ,
    .out_ts     (out_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RATE_SCALER_READOUT_TIMESTAMP_EN
  always @(posedge clk) begin
    if (rst) ts_model <= 32'd0;
    else     ts_model <= ts_model + 32'd1;
  end
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; upd = 4'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    cnt_0 = '0; cnt_1 = '0; cnt_2 = '0; cnt_3 = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_cnt", out_cnt, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);

    // Single update: valid at N+2, gone at N+3.
    out_ready = 1'b1;
    upd = 4'b0001; cnt_0 = 32'h64;
    tick(); upd = 4'b0;
    chk("single_n1_valid", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_chan", out_chan, 0);
    chk("single_cnt", out_cnt, 32'h64);
    chk("single_ovf", out_ovf, 0);
    tick();
    chk("single_n3_valid", out_valid, 0);

    // All channels at once, from a fresh reset so channel 0 leads.
    rst = 1'b1; tick(); rst = 1'b0;
    upd = 4'b1111; cnt_0 = 10; cnt_1 = 11; cnt_2 = 12; cnt_3 = 13;
    tick(); upd = 4'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("all_valid", out_valid, 1);
      chk("all_chan", out_chan, k);
      chk("all_cnt", out_cnt, 10 + k);
      tick();
      chk("all_gap", out_valid, 0);
    end
    chk("all_sticky", ovf_sticky, 0);

    // Fairness: channels 0 and 2 pulse together every 4 cycles.
    for (int c = 0; c < 14; c++) begin
      if (c % 4 == 0 && c < 12) begin
        upd = 4'b0101; cnt_0 = 20 + c / 4; cnt_2 = 30 + c / 4;
      end else begin
        upd = 4'b0;
      end
      if (c >= 1) begin
        if (c % 2 == 0) begin
          chk("rr_valid", out_valid, 1);
          chk("rr_chan", out_chan, (((c - 2) / 2) % 2 == 1) ? 2 : 0);
          chk("rr_cnt", out_cnt, (((c - 2) / 2) % 2 == 1) ? 30 + (c - 2) / 4 : 20 + (c - 2) / 4);
          chk("rr_ovf", out_ovf, 0);
        end else begin
          chk("rr_gap", out_valid, 0);
        end
      end
      tick();
    end
    upd = 4'b0;
    chk("rr_sticky", ovf_sticky, 0);

    // Overflow on channel 1 while channel 0 is held.
    out_ready = 1'b0;
    upd = 4'b0001; cnt_0 = 32'h40;
    tick(); upd = 4'b0;
    tick();
    chk("ovf_hold_valid", out_valid, 1);
    upd = 4'b0010; cnt_1 = 5;
    tick();
    upd = 4'b0010; cnt_1 = 7;
    tick(); upd = 4'b0;
    chk("ovf_sticky_set", ovf_sticky, 4'b0010);
    chk("ovf_stable_chan", out_chan, 0);
    chk("ovf_stable_cnt", out_cnt, 32'h40);
    chk("ovf_stable_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("ovf_drain_gap", out_valid, 0);
    tick();
    chk("ovf_ch1_valid", out_valid, 1);
    chk("ovf_ch1_chan", out_chan, 1);
    chk("ovf_ch1_cnt", out_cnt, 7);
    chk("ovf_ch1_ovf", out_ovf, 1);
    tick();
    chk("ovf_sticky_keep", ovf_sticky, 4'b0010);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("ovf_sticky_clr", ovf_sticky, 4'b0000);

    // Clear and new overflow on the same channel in one cycle: set wins.
    out_ready = 1'b0;
    upd = 4'b0001; cnt_0 = 32'h41;
    tick(); upd = 4'b0;
    tick();
    upd = 4'b0100; cnt_2 = 1;
    tick();
    upd = 4'b0100; cnt_2 = 2; clr_ovf = 1'b1;
    tick(); upd = 4'b0; clr_ovf = 1'b0;
    chk("setwins_sticky", ovf_sticky, 4'b0100);
    out_ready = 1'b1;
    tick(); tick();
    chk("setwins_chan", out_chan, 2);
    chk("setwins_cnt", out_cnt, 2);
    chk("setwins_ovf", out_ovf, 1);
    tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    chk("setwins_clr", ovf_sticky, 4'b0000);

    // Update in the exact grant cycle of channel 0.
    upd = 4'b0001; cnt_0 = 3;
    tick();
    chk("coll_n1_valid", out_valid, 0);
    upd = 4'b0001; cnt_0 = 9;
    tick(); upd = 4'b0;
    chk("coll_w1_chan", out_chan, 0);
    chk("coll_w1_cnt", out_cnt, 3);
    chk("coll_w1_ovf", out_ovf, 0);
    tick();
    chk("coll_gap", out_valid, 0);
    tick();
    chk("coll_w2_valid", out_valid, 1);
    chk("coll_w2_chan", out_chan, 0);
    chk("coll_w2_cnt", out_cnt, 9);
    chk("coll_w2_ovf", out_ovf, 0);
    chk("coll_sticky", ovf_sticky, 0);
    tick();

    // Reset while a word is presented and a sticky flag is set.
    out_ready = 1'b0;
    upd = 4'b0010; cnt_1 = 32'h55;
    tick(); upd = 4'b0;
    tick();
    chk("rstmid_valid_pre", out_valid, 1);
    upd = 4'b0100; cnt_2 = 1; tick();
    upd = 4'b0100; cnt_2 = 2; tick(); upd = 4'b0;
    chk("rstmid_sticky_pre", ovf_sticky, 4'b0100);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_sticky", ovf_sticky, 0);
    out_ready = 1'b1;
    upd = 4'b1000; cnt_3 = 32'h77;
`ifdef RATE_SCALER_READOUT_TIMESTAMP_EN
    ts_at = ts_model;
`endif
    tick(); upd = 4'b0;
    chk("rstmid_n1_valid", out_valid, 0);
    tick();
    chk("rstmid_valid_post", out_valid, 1);
    chk("rstmid_chan", out_chan, 3);
    chk("rstmid_cnt", out_cnt, 32'h77);
    chk("rstmid_ovf", out_ovf, 0);
`ifdef RATE_SCALER_READOUT_TIMESTAMP_EN
    chk("rstmid_ts", out_ts, ts_at);
`endif
    tick();
    chk("rstmid_done", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rate_scaler_readout_arb.md
RATE_SCALER_READOUT_ARB -- requirements
Module: rate_scaler_readout_arb

Interface
REQ-001 Parameter: P_N_WIDTH, default 32, width of every scaler count.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 upd  input  4  per-channel one-cycle update strobes from four rate_scaler_four_lane instances, bit k = channel k.
REQ-005 cnt_0..cnt_3  input  P_N_WIDTH each  channel counts, valid in the cycle the matching upd bit is high.
REQ-006 out_valid  output  1  readout word available.
REQ-007 out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-008 out_chan  output  2  channel index of presented word.
REQ-009 out_cnt  output  P_N_WIDTH  presented count.
REQ-010 out_ovf  output  1  one or more earlier counts of this channel were overwritten before readout.
REQ-011 ovf_sticky  output  4  per-channel sticky overflow flags.
REQ-012 clr_ovf  input  1  one-cycle pulse clears ovf_sticky.

Function
REQ-013 Per channel k: a holding register, a pending bit and an overflow bit; upd[k] captures cnt_k into the holding register and sets pending[k] on the next edge.
REQ-014 FSM states are IDLE and PRESENT.
REQ-015 IDLE: if any pending bit is set, grant the first pending channel in round-robin order starting at last_grant+1 mod 4, load its holding register, index and overflow bit into the output registers, clear its pending and overflow bits, update last_grant, and go to PRESENT; otherwise stay in IDLE.
REQ-016 PRESENT: out_valid=1; out_chan, out_cnt and out_ovf stay stable until the handshake; on out_valid && out_ready, return to IDLE.
REQ-017 Throughput: one word every 2 cycles at most (PRESENT, then IDLE).
REQ-018 Latency: upd[k] at cycle N with the arbiter idle and no other pending channel -> out_valid high from cycle N+2.
REQ-019 An upd[k] while pending[k]=1 and channel k is not granted in that cycle overwrites the holding register and sets overflow[k] and ovf_sticky[k].
REQ-020 An upd[k] in the cycle channel k is granted stores the new count as pending; it is not an overflow; the granted word carries the old count.
REQ-021 An upd[k] while channel k's word sits in PRESENT is a normal capture; it is not an overflow.
REQ-022 Simultaneous upd on several channels are all captured in the same cycle; no count is lost.
REQ-023 If clr_ovf and a new overflow event hit the same channel in the same cycle, the set wins.
REQ-024 out_ready is ignored when out_valid=0.

Reset
REQ-025 rst clears all pending, overflow and ovf_sticky bits; FSM -> IDLE; last_grant=3, so channel 0 has first priority.
REQ-026 Output values after reset: out_valid=0, out_chan=0, out_cnt=0, out_ovf=0, ovf_sticky=0.
REQ-027 rst asserted during PRESENT drops the presented word with no handshake; out_valid is 0 on the following cycle.

Configuration
REQ-028 Macro RATE_SCALER_READOUT_TIMESTAMP_EN: when defined, a free-running 32-bit timestamp counter is added; it resets to 0 and wraps at 2^32-1 -> 0.
REQ-029 With the macro defined, each channel latches the timestamp at its upd and an extra output out_ts[31:0] travels with the word, with the same stability rules as out_cnt.
REQ-030 With the macro undefined, there is no counter, no per-channel timestamp register and no out_ts port; all other behaviour is identical.

Structure
REQ-031 Shared package rate_scaler_pkg holds: channel count constant (4), channel index width (2), FSM state encoding (IDLE, PRESENT), and timestamp width (32).
REQ-032 Sub-module rr_pick4 is combinational: inputs are the 4-bit pending vector and last_grant; outputs are grant_valid and grant index.

Verification
REQ-033 Single update: upd=0001, cnt_0=0x64, out_ready=1 -> out_valid at N+2 with out_chan=0, out_cnt=0x64, out_ovf=0; out_valid=0 at N+3.
REQ-034 All channels at once: upd=1111, cnt_k=10+k, out_ready=1 -> words emitted in channel order 0,1,2,3 with counts 10,11,12,13, two cycles apart.
REQ-035 Round-robin fairness: channels 0 and 2 pulse every 4 cycles, out_ready=1 -> grants alternate 0,2,0,2; no overflow.
REQ-036 Overflow: out_ready=0 with channel 0 presented; upd[1] with cnt 5, then upd[1] with cnt 7 -> channel 1 later read with out_cnt=7, out_ovf=1; ovf_sticky=0010 until a clr_ovf pulse -> 0000.
REQ-037 Grant collision: upd[0] in the exact grant cycle of channel 0 (old 3, new 9) -> words 3 then 9, both with out_ovf=0.
REQ-038 Reset mid-PRESENT: rst for 1 cycle while out_valid=1 -> out_valid=0 next cycle, ovf_sticky=0, next upd[3] granted normally; with TIMESTAMP_EN defined, out_ts equals the counter value at the upd cycle.
